conway_cube_engine: RTL and testbench
=====================================

# conway_cube_engine

Parametrised 3D Conway life engine for the LED cube: holds an N×N×N cell volume and advances it one generation per tick. Runs a SETUP / SIMUL / PAUSE control FSM driven by board buttons and a switch, with configurable birth/survive rules, single-step in pause, a generation counter and auto-pause on extinction or still life. Successor to the fixed 8×8×8 simulator; sits between the cell-entry front end and the cube display driver.

## Interface
- N, 8, cube side length; cell vector width is N³ (N ≥ 3)
- TICK_DIV, 50_000_000, clock cycles per generation in SIMUL (≥ 2)
- BIRTH_MASK, 27'h000_0020, bit k set: dead cell with k live neighbours is born (default B5)
- SURVIVE_MASK, 27'h000_0030, bit k set: live cell with k live neighbours survives (default S45)
- GEN_W, 16, generation counter width
- Clk  in  1  system clock, all logic on rising edge
- Reset  in  1  synchronous, active-high
- BtnL  in  1  return to SETUP (level, edge-detected internally)
- BtnR  in  1  start from SETUP / single-step in PAUSE (edge-detected)
- Sw0  in  1  run enable: 1 run, 0 pause
- Cells  in  N³  setup pattern; bit x + N·y + N²·z is cell (x,y,z)
- Cells_out  out  N³  current generation, same bit mapping
- Gen_count  out  GEN_W  generations computed since leaving SETUP
- q_setup, q_simul, q_pause  out  1 each  one-hot state flags (registered)

## Operation
- Buttons: registered previous value; action on rising edge only (0→1 between consecutive samples); held button acts once.
- SETUP: Cells_out ← Cells every cycle; Gen_count ← 0; tick counter ← 0. BtnR edge → SIMUL.
- SIMUL: tick counter counts 0..TICK_DIV-1; at TICK_DIV-1 one generation update, counter → 0. Sw0=0 → PAUSE (counter held).
- PAUSE: no automatic updates. BtnR edge → one generation update, stay PAUSE. Sw0 rising to 1 → SIMUL, counter resumes from held value.
- BtnL edge in SIMUL or PAUSE → SETUP; BtnL highest priority over all other events.
- Generation update: per cell, count live neighbours among 26 (5-bit sum 0..26); next = live ? SURVIVE_MASK[cnt] : BIRTH_MASK[cnt]. All cells updated simultaneously from the current vector. Gen_count += 1, wraps at 2^GEN_W.
- Auto-pause: if the update result is all zero or equals the current vector, state → PAUSE in the same edge as the update (Gen_count still increments). Sw0 still 1 does not resume; resumption requires Sw0 falling then rising, or BtnR step.
- Simultaneous in PAUSE: BtnR step and Sw0 rising same cycle → step performed, state → SIMUL.

## Timing
- Reset values: q_setup=1, q_simul=0, q_pause=0, Cells_out=0, Gen_count=0, tick counter=0, button history=0.
- Reset mid-run: next edge forces reset values regardless of state.
- SETUP load: Cells sampled at edge t appears on Cells_out after edge t (1-cycle latency).
- BtnR edge in SETUP sampled at edge t → q_simul=1 after edge t+1 (edge detect + state register).
- First SIMUL update: TICK_DIV cycles after entering SIMUL; thereafter every TICK_DIV cycles while running.
- Pause step: Cells_out and Gen_count change one cycle after the detected BtnR edge.
- Neighbour count and rule evaluation are single-cycle combinational from Cells_out.

## Configuration
- CONWAY_WRAP_EN defined: toroidal boundaries; coordinate −1 maps to N−1 and N to 0 on each axis.
- Undefined: cells outside the cube count as dead (open boundaries).

## Test plan
- Reset held 2 cycles → q_setup=1, Cells_out=0, Gen_count=0; Cells=512'h1 in SETUP → Cells_out=512'h1 next cycle.
- N=8, TICK_DIV=4, Cells has only bit 0 set, BtnR pulse → q_simul, after 4 cycles Cells_out=0, Gen_count=1, q_pause=1 (extinction).
- Live (1,1,1),(2,1,1),(3,1,1),(1,2,1),(2,2,1), run one generation → bit 146 (cell 2,2,2) = 1.
- Wrap: live (7,1,1),(7,2,1),(7,3,1),(7,1,2),(7,2,2), one generation → bit 144 (cell 0,2,2) = 1 with CONWAY_WRAP_EN, 0 without.
- SIMUL, Sw0=0 → q_pause, no updates for 20 cycles; BtnR pulse → Gen_count +1 exactly once; Sw0=1 → q_simul.
- BtnL pulse in SIMUL with BtnR simultaneously high → q_setup=1, Gen_count=0, Cells_out follows Cells.

Source files
------------

// File: rtl/conway_cube_engine.sv
// conway_cube_engine: N x N x N 3D life engine with SETUP / SIMUL / PAUSE control.
// Holds the current generation in a register and computes every next-generation
// cell combinationally from it. The whole volume is replaced in one clock edge.
// Optional build macro CONWAY_WRAP_EN: when defined, the faces of the cube wrap
// toroidally. When undefined, cells outside the cube count as dead.
module conway_cube_engine #(
    parameter int          N            = 8,
    parameter int          TICK_DIV     = 50_000_000,
    parameter logic [26:0] BIRTH_MASK   = 27'h000_0020,
    parameter logic [26:0] SURVIVE_MASK = 27'h000_0030,
    parameter int          GEN_W        = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 BtnL,
    input  logic                 BtnR,
    input  logic                 Sw0,
    input  logic [N*N*N-1:0]     Cells,
    output logic [N*N*N-1:0]     Cells_out,
    output logic [GEN_W-1:0]     Gen_count,
    output logic                 q_setup,
    output logic                 q_simul,
    output logic                 q_pause
);

    localparam int CELLS  = N * N * N;
    localparam int IDX_W  = $clog2(CELLS);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_SETUP = 3'b001,
        ST_SIMUL = 3'b010,
        ST_PAUSE = 3'b100
    } state_t;

    state_t              state_reg;
    logic [CELLS-1:0]    cells_reg;
    logic [CELLS-1:0]    cells_next;
    logic [GEN_W-1:0]    gen_reg;
    logic [TICK_W-1:0]   tick_reg;

    // Inputs are registered once, then compared with their previous sample,
    // so every action is taken one edge after the input is first seen.
    logic btnl_reg, btnl_prev_reg;
    logic btnr_reg, btnr_prev_reg;
    logic sw0_reg, sw0_prev_reg;

    logic btnl_edge;
    logic btnr_edge;
    logic sw0_rise;
    logic gen_still;

    assign btnl_edge = btnl_reg & ~btnl_prev_reg;
    assign btnr_edge = btnr_reg & ~btnr_prev_reg;
    assign sw0_rise  = sw0_reg & ~sw0_prev_reg;

    // An update that empties the cube or changes nothing stops the run.
    assign gen_still = (cells_next == '0) || (cells_next == cells_reg);

    // Returns the state of cell (x,y,z); coordinates may be one step outside the cube.
    function automatic logic live_at(input logic [CELLS-1:0] v,
                                     input int x, input int y, input int z);
        int             xi;
        int             yi;
        int             zi;
        logic           hit;
        logic [IDX_W-1:0] idx;
        hit = 1'b1;
`ifdef CONWAY_WRAP_EN
        xi = (x + N) % N;
        yi = (y + N) % N;
        zi = (z + N) % N;
`else
        xi = x;
        yi = y;
        zi = z;
        if (x < 0 || x >= N || y < 0 || y >= N || z < 0 || z >= N) begin
            hit = 1'b0;
        end
`endif
        idx = hit ? IDX_W'(xi + N * yi + N * N * zi) : '0;
        return hit & v[idx];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cell
            localparam int CX = gi % N;
            localparam int CY = (gi / N) % N;
            localparam int CZ = gi / (N * N);

            logic [4:0] nbr_cnt;

            // Sum the 26 surrounding cells of this cell in the current generation.
            always_comb begin
                nbr_cnt = 5'd0;
                for (int dz = -1; dz <= 1; dz++) begin
                    for (int dy = -1; dy <= 1; dy++) begin
                        for (int dx = -1; dx <= 1; dx++) begin
                            if (dx != 0 || dy != 0 || dz != 0) begin
                                nbr_cnt = nbr_cnt +
                                    {4'd0, live_at(cells_reg, CX + dx, CY + dy, CZ + dz)};
                            end
                        end
                    end
                end
            end

            assign cells_next[gi] = cells_reg[gi] ? SURVIVE_MASK[nbr_cnt]
                                                  : BIRTH_MASK[nbr_cnt];
        end
    endgenerate

    // Control FSM together with the cell volume, generation and tick counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= ST_SETUP;
            cells_reg     <= '0;
            gen_reg       <= '0;
            tick_reg      <= '0;
            btnl_reg      <= 1'b0;
            btnl_prev_reg <= 1'b0;
            btnr_reg      <= 1'b0;
            btnr_prev_reg <= 1'b0;
            sw0_reg       <= 1'b0;
            sw0_prev_reg  <= 1'b0;
        end else begin
            btnl_reg      <= BtnL;
            btnl_prev_reg <= btnl_reg;
            btnr_reg      <= BtnR;
            btnr_prev_reg <= btnr_reg;
            sw0_reg       <= Sw0;
            sw0_prev_reg  <= sw0_reg;

            case (state_reg)
                ST_SETUP: begin
                    cells_reg <= Cells;
                    gen_reg   <= '0;
                    tick_reg  <= '0;
                    if (btnr_edge) begin
                        state_reg <= ST_SIMUL;
                    end
                end
                ST_SIMUL: begin
                    if (btnl_edge) begin
                        state_reg <= ST_SETUP;
                        gen_reg   <= '0;
                        tick_reg  <= '0;
                    end else if (!sw0_reg) begin
                        // Tick counter is held so the run resumes mid-period.
                        state_reg <= ST_PAUSE;
                    end else if (tick_reg == TICK_LAST) begin
                        tick_reg  <= '0;
                        cells_reg <= cells_next;
                        gen_reg   <= gen_reg + GEN_W'(1);
                        if (gen_still) begin
                            state_reg <= ST_PAUSE;
                        end
                    end else begin
                        tick_reg <= tick_reg + TICK_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (btnl_edge) begin
                        state_reg <= ST_SETUP;
                        gen_reg   <= '0;
                        tick_reg  <= '0;
                    end else begin
                        if (btnr_edge) begin
                            cells_reg <= cells_next;
                            gen_reg   <= gen_reg + GEN_W'(1);
                        end
                        // A step that stalls the cube keeps it paused even on resume.
                        if (sw0_rise && !(btnr_edge && gen_still)) begin
                            state_reg <= ST_SIMUL;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_SETUP;
                end
            endcase
        end
    end

    assign Cells_out = cells_reg;
    assign Gen_count = gen_reg;
    assign q_setup   = (state_reg == ST_SETUP);
    assign q_simul   = (state_reg == ST_SIMUL);
    assign q_pause   = (state_reg == ST_PAUSE);

endmodule

// File: tb/tb_conway_cube_engine.sv
// tb_conway_cube_engine: table of single-generation runs plus hand-written
// sequences for pause/step/resume, BtnL priority and reset mid-run.
module tb_conway_cube_engine;

    localparam int          N     = 8;
    localparam int          TD    = 4;
    localparam int          GW    = 16;
    localparam int          CELLS = N * N * N;
    localparam logic [26:0] BIRTH = 27'h000_0020;
    localparam logic [26:0] SURV  = 27'h000_0030;

    logic             clk;
    logic             Reset;
    logic             BtnL;
    logic             BtnR;
    logic             Sw0;
    logic [CELLS-1:0] Cells;
    logic [CELLS-1:0] Cells_out;
    logic [GW-1:0]    Gen_count;
    logic             q_setup;
    logic             q_simul;
    logic             q_pause;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [CELLS-1:0] cells;
        logic [GW-1:0]    gen;
        logic             pause;
    } exp_t;

    typedef struct {
        logic [CELLS-1:0] pat;
        int               probe;
        logic             val;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[5];

    conway_cube_engine #(
        .N(N), .TICK_DIV(TD), .BIRTH_MASK(BIRTH), .SURVIVE_MASK(SURV), .GEN_W(GW)
    ) dut (
        .Clk(clk), .Reset(Reset), .BtnL(BtnL), .BtnR(BtnR), .Sw0(Sw0),
        .Cells(Cells), .Cells_out(Cells_out), .Gen_count(Gen_count),
        .q_setup(q_setup), .q_simul(q_simul), .q_pause(q_pause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [CELLS-1:0] at(input int x, input int y, input int z);
        logic [CELLS-1:0] one;
        one = 1;
        return one << (x + N * y + N * N * z);
    endfunction

    // Reference model: every live cell scatters a vote into its neighbours.
    function automatic logic [CELLS-1:0] life_step(input logic [CELLS-1:0] v);
        int               cnt [CELLS];
        logic [CELLS-1:0] r;
        int               x, y, z, nx, ny, nz;
        logic             ok;
        for (int i = 0; i < CELLS; i++) cnt[i] = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (v[i]) begin
                x = i % N; y = (i / N) % N; z = i / (N * N);
                for (int dz = -1; dz <= 1; dz++)
                    for (int dy = -1; dy <= 1; dy++)
                        for (int dx = -1; dx <= 1; dx++) begin
                            nx = x + dx; ny = y + dy; nz = z + dz;
`ifdef CONWAY_WRAP_EN
                            nx = (nx + N) % N; ny = (ny + N) % N; nz = (nz + N) % N;
                            ok = 1'b1;
`else
                            ok = (nx >= 0 && nx < N && ny >= 0 && ny < N && nz >= 0 && nz < N);
`endif
                            if (ok && !(dx == 0 && dy == 0 && dz == 0))
                                cnt[nx + N * ny + N * N * nz]++;
                        end
            end
        end
        for (int i = 0; i < CELLS; i++) r[i] = v[i] ? SURV[cnt[i]] : BIRTH[cnt[i]];
        return r;
    endfunction

    task automatic chk_vec(input string name, input logic [CELLS-1:0] act, input logic [CELLS-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else $display("ok   %s", name);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else $display("ok   %s = %0d", name, act);
    endtask

    task automatic push_exp(input logic [CELLS-1:0] cur, input int gen, input logic force_pause);
        exp_t e;
        e.cells = life_step(cur);
        e.gen   = GW'(gen);
        e.pause = force_pause || (e.cells == '0) || (e.cells == cur);
        sb.push_back(e);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            errors++; checks++;
            $display("FAIL %s: scoreboard empty, got gen %0d", tag, Gen_count);
        end else begin
            e = sb.pop_front();
            chk_vec({tag, "-cells"}, Cells_out, e.cells);
            chk_int({tag, "-gen"}, int'(Gen_count), int'(e.gen));
            chk_int({tag, "-pause"}, int'(q_pause), int'(e.pause));
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic to_setup();
        BtnL = 1'b1; cyc(1);
        BtnL = 1'b0; cyc(2);
    endtask

    // Load a pattern, start, and check the first generation and its latency.
    task automatic run_gen(input int id, input logic [CELLS-1:0] pat, input int probe, input logic val);
        int    lat;
        string tag;
        tag = $sformatf("vec%0d", id);
        Cells = pat; cyc(1);
        chk_vec({tag, "-load"}, Cells_out, pat);
        push_exp(pat, 1, 1'b0);
        BtnR = 1'b1; lat = 0;
        while (Gen_count == 0 && lat < 30) begin
            cyc(1); lat++; BtnR = 1'b0;
        end
        chk_int({tag, "-latency"}, lat, 2 + TD);
        sb_check(tag);
        if (probe >= 0) chk_int({tag, "-probe"}, int'(Cells_out[probe]), int'(val));
        if (q_pause) begin
            cyc(TD + 2);
            chk_int({tag, "-stays-paused"}, int'(q_pause), 1);
            chk_int({tag, "-no-more-gen"}, int'(Gen_count), 1);
        end
        to_setup();
        chk_int({tag, "-back-setup"}, int'(q_setup), 1);
    endtask

    logic [CELLS-1:0] pat_a;
    logic [CELLS-1:0] pat_b;
    logic [CELLS-1:0] g1;
    int               wait_cnt;

    initial begin
        pat_a = at(1,1,1) | at(2,1,1) | at(3,1,1) | at(1,2,1) | at(2,2,1);
        pat_b = {16{32'hA5A5_0F0F}};
        vecs[0] = '{at(0,0,0), 0, 1'b0};
        vecs[1] = '{pat_a, 146, 1'b1};
`ifdef CONWAY_WRAP_EN
        vecs[2] = '{at(7,1,1) | at(7,2,1) | at(7,3,1) | at(7,1,2) | at(7,2,2), 144, 1'b1};
`else
        vecs[2] = '{at(7,1,1) | at(7,2,1) | at(7,3,1) | at(7,1,2) | at(7,2,2), 144, 1'b0};
`endif
        vecs[3] = '{at(3,3,3) | at(4,3,3) | at(3,4,3) | at(4,4,3), 219, 1'b0};
        vecs[4].probe = -1;
        vecs[4].val   = 1'b0;
        for (int i = 0; i < 16; i++) vecs[4].pat[32*i +: 32] = $urandom & $urandom & $urandom;

        // Reset dominates even with a full pattern on Cells.
        Reset = 1'b1; BtnL = 1'b0; BtnR = 1'b0; Sw0 = 1'b1; Cells = '1;
        cyc(2);
        chk_int("rst-q_setup", int'(q_setup), 1);
        chk_int("rst-q_simul", int'(q_simul), 0);
        chk_int("rst-q_pause", int'(q_pause), 0);
        chk_vec("rst-cells", Cells_out, '0);
        chk_int("rst-gen", int'(Gen_count), 0);
        Reset = 1'b0; Cells = 1;
        cyc(1);
        chk_vec("setup-load-1", Cells_out, 1);

        for (int i = 0; i < 5; i++) run_gen(i, vecs[i].pat, vecs[i].probe, vecs[i].val);

        // Pause, idle, single step (held button acts once), resume mid-period.
        Cells = pat_a; cyc(1);
        BtnR = 1'b1; cyc(1);
        chk_int("start-not-yet", int'(q_simul), 0);
        BtnR = 1'b0; cyc(1);
        chk_int("start-q_simul", int'(q_simul), 1);
        Sw0 = 1'b0; cyc(2);
        chk_int("pause-q_pause", int'(q_pause), 1);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk_int($sformatf("pause-idle-gen%0d", i), int'(Gen_count), 0);
        end
        push_exp(pat_a, 1, 1'b1);
        g1 = life_step(pat_a);
        BtnR = 1'b1; cyc(1);
        chk_int("step-not-yet", int'(Gen_count), 0);
        cyc(1);
        sb_check("step");
        cyc(4);
        chk_int("step-held-once", int'(Gen_count), 1);
        BtnR = 1'b0; Sw0 = 1'b1; cyc(1);
        chk_int("resume-not-yet", int'(q_pause), 1);
        cyc(1);
        chk_int("resume-q_simul", int'(q_simul), 1);
        push_exp(g1, 2, 1'b0);
        cyc(2);
        chk_int("resume-held-tick", int'(Gen_count), 1);
        cyc(1);
        sb_check("resume-gen2");
        to_setup();

        // BtnL wins over a simultaneous BtnR while running.
        Cells = pat_a; cyc(1);
        BtnR = 1'b1; cyc(1); BtnR = 1'b0;
        wait_cnt = 0;
        while (Gen_count == 0 && wait_cnt < 30) begin cyc(1); wait_cnt++; end
        chk_int("btnl-ran-gen", int'(Gen_count), 1);
        BtnL = 1'b1; BtnR = 1'b1; cyc(2);
        chk_int("btnl-q_setup", int'(q_setup), 1);
        chk_int("btnl-gen", int'(Gen_count), 0);
        Cells = pat_b; cyc(1);
        chk_vec("btnl-follow", Cells_out, pat_b);
        cyc(3);
        chk_int("btnl-stay-setup", int'(q_setup), 1);
        BtnL = 1'b0; BtnR = 1'b0; cyc(2);

        // Reset in the middle of a run.
        Cells = pat_a; cyc(1);
        BtnR = 1'b1; cyc(1); BtnR = 1'b0; cyc(3);
        chk_int("midrun-q_simul", int'(q_simul), 1);
        Reset = 1'b1; cyc(1);
        chk_int("midrun-rst-q_setup", int'(q_setup), 1);
        chk_int("midrun-rst-q_simul", int'(q_simul), 0);
        chk_vec("midrun-rst-cells", Cells_out, '0);
        chk_int("midrun-rst-gen", int'(Gen_count), 0);
        Reset = 1'b0; cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
